// File: rtl/chan_copy_pipe.sv
// chan_copy_pipe: multi-lane registered copy pipeline with a valid/ready
// handshake, a per-beat lane transform applied on entry, and a wrapping
// counter of completed output transfers.
module chan_copy_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]          xfer_count
);

  localparam int DW = CHANNELS * WIDTH;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [DEPTH-1:0]         adv;
  logic [DW-1:0]            xform;
  logic [CNT_W-1:0]         count_q, count_d;

  // Transform the incoming beat according to its mode before it enters stage 0
  always_comb begin
    xform = in_data;
    case (in_mode)
      2'd0: xform = in_data;
      2'd1: xform = ~in_data;
      2'd2: begin
        for (int k = 0; k < CHANNELS; k++) begin
          for (int i = 0; i < WIDTH; i++) begin
            xform[k*WIDTH + i] = in_data[k*WIDTH + (WIDTH-1-i)];
          end
        end
      end
      default: begin
        for (int k = 0; k < CHANNELS; k++) begin
          xform[k*WIDTH +: WIDTH] = in_data[((k+1) % CHANNELS)*WIDTH +: WIDTH];
        end
      end
    endcase
  end

  // Advance chain from the output back to stage 0, so an empty slot anywhere downstream lets earlier stages move
  always_comb begin
    logic chain;
    adv   = '0;
    chain = out_ready;
    for (int s = DEPTH-1; s >= 0; s--) begin
      chain  = !valid_q[s] || chain;
      adv[s] = chain;
    end
  end

  // Next-state for every stage plus the transfer counter
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = xform;
    end
    for (int s = 1; s < DEPTH; s++) begin
      if (adv[s]) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
      end
    end
    if (valid_q[DEPTH-1] && out_ready) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset discards every in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign in_ready   = adv[0];
  assign out_valid  = valid_q[DEPTH-1];
  assign out_data   = data_q[DEPTH-1];
  assign xfer_count = count_q;

endmodule

// File: tb/tb_chan_copy_pipe.sv
// tb_chan_copy_pipe: directed scoreboard bench for chan_copy_pipe. Stimulus
// pushes the hand-computed result of each accepted beat into a queue; an
// independent monitor pops and compares on every output handshake.
module tb_chan_copy_pipe;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 2;
  // Narrow counter so the wrap from 15 to 0 is reachable in a short run
  localparam int CNT_W    = 4;
  localparam int DW       = WIDTH * CHANNELS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_mode = 2'd0;
  logic [DW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] xfer_count;

  int nVectors = 0;
  int nMiscompares = 0;
  logic [DW-1:0] expQ[$];

  chan_copy_pipe #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for acceptance, record its expected result
  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] data, input logic [31:0] expected);
    int cycles;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    #1;
    cycles = 0;
    while (!in_ready && cycles < 50) begin
      tick();
      cycles++;
    end
    if (!in_ready) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL accept timeout: got in_ready=0, expected 1 within 50 cycles");
    end else begin
      expQ.push_back(expected);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has been seen at the output
  task automatic waitDrain();
    int cycles;
    cycles = 0;
    while (expQ.size() != 0 && cycles < 50) begin
      tick();
      cycles++;
    end
    if (expQ.size() != 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL drain timeout: got %0d beats pending, expected 0", expQ.size());
    end
  endtask

  // Hold reset for three cycles with a live beat on the input, then release
  task automatic resetDut();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_mode  = 2'd0;
    in_data  = 32'hDEADBEEF;
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpected beat: got %h, expected no output", out_data);
      end else begin
        checkOutput("beat data", out_data, expQ.pop_front());
      end
    end
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    // Reset with a valid beat presented throughout
    resetDut();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'h0);
    checkOutput("reset xfer_count", 32'(xfer_count), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Latency and pass-through
    resetDut();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(2'd0, 32'h44332211, 32'h44332211);
    checkOutput("latency not early", 32'(out_valid), 32'd0);
    tick();
    checkOutput("latency out_valid", 32'(out_valid), 32'd1);
    checkOutput("latency out_data", out_data, 32'h44332211);
    tick();
    checkOutput("latency xfer_count", 32'(xfer_count), 32'd1);

    // Transforms back to back
    resetDut();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(2'd1, 32'h80C0F001, 32'h7F3F0FFE);
    applyStimulus(2'd2, 32'h80C0F001, 32'h01030F80);
    applyStimulus(2'd3, 32'h80C0F001, 32'h0180C0F0);
    checkOutput("bitrev consecutive", out_data, 32'h01030F80);
    tick();
    checkOutput("rotate consecutive", out_data, 32'h0180C0F0);
    waitDrain();
    checkOutput("transform xfer_count", 32'(xfer_count), 32'd3);

    // Backpressure: pipe fills, output holds, then drains in order
    resetDut();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    applyStimulus(2'd0, 32'd1, 32'd1);
    applyStimulus(2'd0, 32'd2, 32'd2);
    checkOutput("full in_ready", 32'(in_ready), 32'd0);
    checkOutput("stall out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall out_data", out_data, 32'd1);
    tick();
    tick();
    checkOutput("held out_data", out_data, 32'd1);
    checkOutput("held in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    applyStimulus(2'd0, 32'd3, 32'd3);
    applyStimulus(2'd0, 32'd4, 32'd4);
    waitDrain();
    checkOutput("backpressure xfer_count", 32'(xfer_count), 32'd4);

    // Counter wrap over 17 transfers
    resetDut();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(2'd0, i * 32'h01010101, i * 32'h01010101);
    end
    waitDrain();
    checkOutput("count after 15", 32'(xfer_count), 32'd15);
    applyStimulus(2'd1, 32'h0F0F0F0F, 32'hF0F0F0F0);
    waitDrain();
    checkOutput("count after 16", 32'(xfer_count), 32'd0);
    applyStimulus(2'd3, 32'hAABBCCDD, 32'hDDAABBCC);
    waitDrain();
    checkOutput("count after 17", 32'(xfer_count), 32'd1);

    // Mid-flight reset discards two queued beats and clears the counter
    resetDut();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(2'd0, 32'h12345678, 32'h12345678);
    waitDrain();
    checkOutput("pre-reset xfer_count", 32'(xfer_count), 32'd1);
    out_ready = 1'b0;
    applyStimulus(2'd0, 32'hA1A2A3A4, 32'hA1A2A3A4);
    applyStimulus(2'd0, 32'hB1B2B3B4, 32'hB1B2B3B4);
    checkOutput("in-flight out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset xfer_count", 32'(xfer_count), 32'd0);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("post-reset xfer_count", 32'(xfer_count), 32'd0);

    checkOutput("scoreboard empty", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/chan_copy_pipe.md
Name: chan_copy_pipe

Overview:
- Parametrised successor to the single-bit copy primitive: moves CHANNELS lanes of WIDTH bits from input to output through a DEPTH-stage registered pipeline with a valid/ready handshake.
- Each beat carries a per-beat transform mode: pass, invert, bit-reverse, or lane-rotate.
- Used as a regression and synthesis target for multi-lane datapath copying with backpressure.
- Includes a wrapping counter of completed output transfers.

Parameters:
- WIDTH, 8, bits per channel lane (>=1)
- CHANNELS, 4, number of lanes (>=1)
- DEPTH, 2, pipeline stages, i.e. latency in cycles (>=1)
- CNT_W, 16, width of the transfer counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  stage 0 can accept a beat
- in_mode  input  2  transform for this beat: 0 pass, 1 invert, 2 bit-reverse per lane, 3 lane-rotate
- in_data  input  CHANNELS*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  last stage holds a beat
- out_ready  input  1  downstream accepts
- out_data  output  CHANNELS*WIDTH  transformed beat
- xfer_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, all stage data = 0, xfer_count = 0.
  - Consequently out_valid = 0 and out_data = 0; in_ready = 1 once reset deasserts.
- Reset mid-operation: all in-flight beats are discarded with no output; the counter clears.
- Stages s = 0..DEPTH-1 each hold a valid bit and a data register; stage DEPTH-1 drives out_valid and out_data.
- Advance rule:
  - adv[DEPTH-1] = !valid[DEPTH-1] || out_ready
  - adv[s] = !valid[s] || adv[s+1]
  - in_ready = adv[0] (combinational, so bubbles collapse).
- Stage 0: when adv[0] is true, it loads valid = in_valid and data = T(in_mode, in_data). Data may load on an invalid beat; only valid bits are checked.
- Stage s>0: when adv[s] is true, it loads valid and data from stage s-1.
- When adv[s] is false, the stage holds.
- Transform T (combinational, applied only at stage 0 capture):
  - Mode 0: identity.
  - Mode 1: bitwise NOT of all bits.
  - Mode 2: each lane bit-reversed; out lane bit i = in lane bit WIDTH-1-i.
  - Mode 3: out lane k = in lane (k+1) mod CHANNELS. With CHANNELS=1 this is identity.
- Latency: a beat accepted at edge n appears on out_valid after edge n+DEPTH-1, i.e. it is visible DEPTH cycles after acceptance with no stall.
- Throughput: one beat per cycle with continuous out_ready.
- Backpressure: while out_valid && !out_ready, out_data is stable. Upstream stages fill any bubbles; in_ready drops only when every stage is valid.
- Simultaneous accept and drain on a full pipe: in_ready = 1 when out_ready = 1, and the pipe shifts with no loss or duplication.
- Ordering: strict FIFO; no beat is reordered, dropped or duplicated.
- xfer_count increments by 1 on each edge where out_valid && out_ready, and wraps from 2^CNT_W-1 to 0.
- Input values are don't-care while in_valid = 0.

Test Plan:
- Reset: assert rst_n=0 for 3 cycles with in_valid=1 and in_data=32'hDEADBEEF, then release -> out_valid=0, out_data=0, xfer_count=0, in_ready=1.
- Latency/pass-through: out_ready=1; send in_data=32'h44332211 with mode 0 at cycle 0 -> out_valid=1 with out_data=32'h44332211 exactly 2 cycles later; xfer_count=1 afterwards.
- Transforms: send 32'h80C0F001 with modes 1,2,3 back-to-back -> 32'h7F3F0FFE, 32'h01030F80, 32'h0180C0F0 on consecutive cycles.
- Backpressure: hold out_ready=0 and stream 4 beats (values 1..4) -> in_ready drops after 2 accepted beats and out_data holds 1. Release -> outputs 1,2,3,4 in order, none lost or duplicated, xfer_count=4.
- Mid-flight reset: 2 beats in flight, pulse rst_n low for half a cycle -> out_valid goes 0 immediately, neither beat ever emerges, xfer_count=0.
- Counter wrap: with CNT_W=4, complete 17 transfers -> xfer_count reads 15 after the 15th, 0 after the 16th and 1 after the 17th.
